// File: rtl/spu_pkg.sv
// Shared field layout of the packed pipe result word, sizing constants and unit ids.
package spu_pkg;

  localparam int NUM_STAGES = 7;
  localparam int NUM_REGS   = 128;
  localparam int DATA_W     = 128;
  localparam int REG_AW     = 7;
  localparam int LAT_W      = 4;
  localparam int CNT_W      = 3;

  // Packed word: {reg_wr, latency, reg_dst, result, unit}
  localparam int UNIT_LSB  = 0;
  localparam int UNIT_MSB  = 2;
  localparam int RES_LSB   = 3;
  localparam int RES_MSB   = 130;
  localparam int DST_LSB   = 131;
  localparam int DST_MSB   = 137;
  localparam int LAT_LSB   = 138;
  localparam int LAT_MSB   = 141;
  localparam int REGWR_BIT = 142;
  localparam int PACKED_W  = 143;

  typedef enum logic [2:0] {
    FX1  = 3'b000,
    FX2  = 3'b001,
    SP   = 3'b010,
    BYTE = 3'b011
  } unit_e;

  // Out-of-range issue latencies are treated as the longest pipe.
  function automatic logic [CNT_W-1:0] clamp_lat(input logic [LAT_W-1:0] lat);
    if (lat == '0 || lat > 4'd7) begin
      return 3'd7;
    end
    return lat[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/operand_forward_unit_fwd_select.sv
// Priority match of one source operand over the even/odd forwarding stages, falling back to RF.
module fwd_select
  import spu_pkg::*;
(
  input  logic [PACKED_W-1:0] e_stage_i [NUM_STAGES],
  input  logic [PACKED_W-1:0] o_stage_i [NUM_STAGES],
  input  logic [REG_AW-1:0]   src_i,
  input  logic [DATA_W-1:0]   rf_i,
  output logic [DATA_W-1:0]   data_o,
  output logic                hit_o
);

  logic [NUM_STAGES-1:0] e_match;
  logic [NUM_STAGES-1:0] o_match;

  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_match
    assign e_match[gi] = e_stage_i[gi][REGWR_BIT] &&
                         (e_stage_i[gi][DST_MSB:DST_LSB] == src_i) &&
                         (e_stage_i[gi][LAT_MSB:LAT_LSB] <= LAT_W'(gi + 1));
    assign o_match[gi] = o_stage_i[gi][REGWR_BIT] &&
                         (o_stage_i[gi][DST_MSB:DST_LSB] == src_i) &&
                         (o_stage_i[gi][LAT_MSB:LAT_LSB] <= LAT_W'(gi + 1));
    logic unit_unused;
    assign unit_unused = ^{e_stage_i[gi][UNIT_MSB:UNIT_LSB], o_stage_i[gi][UNIT_MSB:UNIT_LSB]};
  end

  // Walk from the oldest stage down so the youngest match, and even at a tie, overrides last.
  always_comb begin
    data_o = rf_i;
    hit_o  = 1'b0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      if (o_match[k]) begin
        data_o = o_stage_i[k][RES_MSB:RES_LSB];
        hit_o  = 1'b1;
      end
      if (e_match[k]) begin
        data_o = e_stage_i[k][RES_MSB:RES_LSB];
        hit_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/operand_forward_unit.sv
// Pending-register scoreboard, issue stall and registered operand forwarding for both pipes.
// Optional stall/forward-hit performance counters are built when FWD_PERF_CNT_EN is defined.
module operand_forward_unit
  import spu_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [PACKED_W-1:0] e_stage1, e_stage2, e_stage3, e_stage4, e_stage5, e_stage6, e_stage7,
  input  logic [PACKED_W-1:0] o_stage1, o_stage2, o_stage3, o_stage4, o_stage5, o_stage6, o_stage7,
  input  logic                e_issue_valid,
  input  logic                o_issue_valid,
  input  logic                e_issue_reg_wr,
  input  logic                o_issue_reg_wr,
  input  logic [REG_AW-1:0]   e_issue_dst,
  input  logic [REG_AW-1:0]   o_issue_dst,
  input  logic [LAT_W-1:0]    e_issue_lat,
  input  logic [LAT_W-1:0]    o_issue_lat,
  input  logic [REG_AW-1:0]   e_ra_addr, e_rb_addr, e_rc_addr,
  input  logic [REG_AW-1:0]   o_ra_addr, o_rb_addr, o_rc_addr,
  input  logic [DATA_W-1:0]   e_ra_rf, e_rb_rf, e_rc_rf,
  input  logic [DATA_W-1:0]   o_ra_rf, o_rb_rf, o_rc_rf,
  output logic [DATA_W-1:0]   e_ra_data, e_rb_data, e_rc_data,
  output logic [DATA_W-1:0]   o_ra_data, o_rb_data, o_rc_data,
  output logic                stall,
  output logic                dual_dst_err,
  output logic [31:0]         stall_cycles,
  output logic [31:0]         fwd_hits
);

  localparam int NUM_OPS = 6;

  logic [PACKED_W-1:0] e_stg [NUM_STAGES];
  logic [PACKED_W-1:0] o_stg [NUM_STAGES];
  logic [REG_AW-1:0]   src   [NUM_OPS];
  logic [DATA_W-1:0]   rf    [NUM_OPS];
  logic [DATA_W-1:0]   sel   [NUM_OPS];
  logic [DATA_W-1:0]   op_q  [NUM_OPS];
  logic [NUM_OPS-1:0]  op_hit;
  logic [CNT_W-1:0]    cnt_q [NUM_REGS];
  logic [CNT_W-1:0]    cnt_d [NUM_REGS];
  logic                e_load, o_load;
  logic                dual_dst_err_q;

  assign e_stg = '{e_stage1, e_stage2, e_stage3, e_stage4, e_stage5, e_stage6, e_stage7};
  assign o_stg = '{o_stage1, o_stage2, o_stage3, o_stage4, o_stage5, o_stage6, o_stage7};
  assign src   = '{e_ra_addr, e_rb_addr, e_rc_addr, o_ra_addr, o_rb_addr, o_rc_addr};
  assign rf    = '{e_ra_rf, e_rb_rf, e_rc_rf, o_ra_rf, o_rb_rf, o_rc_rf};

  for (genvar gi = 0; gi < NUM_OPS; gi++) begin : g_sel
    fwd_select u_fwd_select (
      .e_stage_i (e_stg),
      .o_stage_i (o_stg),
      .src_i     (src[gi]),
      .rf_i      (rf[gi]),
      .data_o    (sel[gi]),
      .hit_o     (op_hit[gi])
    );
  end

  always_comb begin
    stall = 1'b0;
    for (int i = 0; i < NUM_OPS; i++) begin
      if (cnt_q[src[i]] != '0) stall = 1'b1;
    end
  end

  assign e_load = e_issue_valid && e_issue_reg_wr && !stall;
  assign o_load = o_issue_valid && o_issue_reg_wr && !stall;

  // Loads override the decrement; the odd load is applied last so it wins a shared dst.
  always_comb begin
    for (int r = 0; r < NUM_REGS; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - 3'd1 : '0;
    end
    if (e_load) cnt_d[e_issue_dst] = clamp_lat(e_issue_lat);
    if (o_load) cnt_d[o_issue_dst] = clamp_lat(o_issue_lat);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) cnt_q[r] <= '0;
      for (int i = 0; i < NUM_OPS; i++) op_q[i] <= '0;
      dual_dst_err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      if (!stall) op_q <= sel;
      dual_dst_err_q <= e_load && o_load && (e_issue_dst == o_issue_dst);
    end
  end

  assign e_ra_data    = op_q[0];
  assign e_rb_data    = op_q[1];
  assign e_rc_data    = op_q[2];
  assign o_ra_data    = op_q[3];
  assign o_rb_data    = op_q[4];
  assign o_rc_data    = op_q[5];
  assign dual_dst_err = dual_dst_err_q;

`ifdef FWD_PERF_CNT_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] fwd_hits_q;
  logic [2:0]  hit_cnt;
  logic [32:0] hits_sum;

  always_comb begin
    hit_cnt = '0;
    for (int i = 0; i < NUM_OPS; i++) hit_cnt = hit_cnt + 3'(op_hit[i]);
  end

  assign hits_sum = {1'b0, fwd_hits_q} + 33'(hit_cnt);

  // Hits are only counted on cycles where the operands are actually latched.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles_q <= '0;
      fwd_hits_q     <= '0;
    end else begin
      if (stall && stall_cycles_q != '1) stall_cycles_q <= stall_cycles_q + 32'd1;
      if (!stall) fwd_hits_q <= hits_sum[32] ? '1 : hits_sum[31:0];
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign fwd_hits     = fwd_hits_q;
`else
  logic perf_unused;
  assign perf_unused  = ^op_hit;
  assign stall_cycles = '0;
  assign fwd_hits     = '0;
`endif

endmodule

// File: tb/tb_operand_forward_unit.sv
// Scoreboard bench: the driver models each cycle from the forwarding rules and queues the
// expected outputs; an independent monitor pops and compares them mid-cycle.
module tb_operand_forward_unit;
  import spu_pkg::*;

  logic                clk;
  logic                rst;
  logic [PACKED_W-1:0] e_st [NUM_STAGES];
  logic [PACKED_W-1:0] o_st [NUM_STAGES];
  logic                e_iv, o_iv, e_wr, o_wr;
  logic [6:0]          e_dst, o_dst;
  logic [3:0]          e_lat, o_lat;
  logic [6:0]          src  [6];
  logic [127:0]        rf   [6];
  logic [127:0]        dout [6];
  logic                stall, dual_dst_err;
  logic [31:0]         stall_cycles, fwd_hits;

  typedef struct packed {
    logic              chk;
    logic              stall;
    logic              err;
    logic [5:0][127:0] op;
    logic [31:0]       sc;
    logic [31:0]       fh;
    logic [31:0]       cyc;
  } exp_t;

  exp_t              q[$];
  int unsigned       ready [NUM_REGS];
  int unsigned       cyc;
  logic [5:0][127:0] m_op;
  logic              m_err;
  int unsigned       m_sc, m_fh;
  int                n_chk, n_fail;
  string             names [6] = '{"e_ra_data", "e_rb_data", "e_rc_data",
                                   "o_ra_data", "o_rb_data", "o_rc_data"};

  operand_forward_unit dut (
    .clk(clk), .rst(rst),
    .e_stage1(e_st[0]), .e_stage2(e_st[1]), .e_stage3(e_st[2]), .e_stage4(e_st[3]),
    .e_stage5(e_st[4]), .e_stage6(e_st[5]), .e_stage7(e_st[6]),
    .o_stage1(o_st[0]), .o_stage2(o_st[1]), .o_stage3(o_st[2]), .o_stage4(o_st[3]),
    .o_stage5(o_st[4]), .o_stage6(o_st[5]), .o_stage7(o_st[6]),
    .e_issue_valid(e_iv), .o_issue_valid(o_iv),
    .e_issue_reg_wr(e_wr), .o_issue_reg_wr(o_wr),
    .e_issue_dst(e_dst), .o_issue_dst(o_dst),
    .e_issue_lat(e_lat), .o_issue_lat(o_lat),
    .e_ra_addr(src[0]), .e_rb_addr(src[1]), .e_rc_addr(src[2]),
    .o_ra_addr(src[3]), .o_rb_addr(src[4]), .o_rc_addr(src[5]),
    .e_ra_rf(rf[0]), .e_rb_rf(rf[1]), .e_rc_rf(rf[2]),
    .o_ra_rf(rf[3]), .o_rb_rf(rf[4]), .o_rc_rf(rf[5]),
    .e_ra_data(dout[0]), .e_rb_data(dout[1]), .e_rc_data(dout[2]),
    .o_ra_data(dout[3]), .o_rb_data(dout[4]), .o_rc_data(dout[5]),
    .stall(stall), .dual_dst_err(dual_dst_err),
    .stall_cycles(stall_cycles), .fwd_hits(fwd_hits)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [142:0] pk(input logic wr, input logic [6:0] dst,
                                      input logic [3:0] lat, input logic [127:0] res);
    return {wr, lat, dst, res, 3'b010};
  endfunction

  function automatic int unsigned eff_lat(input logic [3:0] l);
    return (l == 0 || l > 7) ? 7 : int'(l);
  endfunction

  function automatic bit fwdable(input logic [142:0] w, input logic [6:0] a, input int k);
    return w[142] && (w[137:131] == a) && (int'(w[141:138]) <= k);
  endfunction

  // Youngest forwardable stage wins, even before odd at the same age, else RF.
  function automatic logic [128:0] fwd_model(input logic [6:0] a, input logic [127:0] rfv);
    for (int k = 1; k <= 7; k++) begin
      if (fwdable(e_st[k-1], a, k)) return {1'b1, e_st[k-1][130:3]};
      if (fwdable(o_st[k-1], a, k)) return {1'b1, o_st[k-1][130:3]};
    end
    return {1'b0, rfv};
  endfunction

  task automatic check(input string nm, input logic [31:0] c,
                       input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, c, act, exp);
    end
  endtask

  // Register r is pending until cycle ready[r]; an issue at t with latency L is ready at t+L+1.
  task automatic do_cycle();
    exp_t        e;
    logic        st;
    logic [128:0] f;
    st = 1'b0;
    for (int i = 0; i < 6; i++) if (ready[src[i]] > cyc) st = 1'b1;
    e.chk = (cyc != 0); e.stall = st; e.err = m_err; e.op = m_op;
    e.sc = m_sc; e.fh = m_fh; e.cyc = cyc;
    q.push_back(e);
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) ready[r] = 0;
      m_op = '0; m_err = 1'b0; m_sc = 0; m_fh = 0;
    end else begin
      m_err = !st && e_iv && e_wr && o_iv && o_wr && (e_dst == o_dst);
      if (!st) begin
        for (int i = 0; i < 6; i++) begin
          f = fwd_model(src[i], rf[i]);
          m_op[i] = f[127:0];
`ifdef FWD_PERF_CNT_EN
          if (f[128]) m_fh++;
`endif
        end
        if (e_iv && e_wr) ready[e_dst] = cyc + 1 + eff_lat(e_lat);
        if (o_iv && o_wr) ready[o_dst] = cyc + 1 + eff_lat(o_lat);
      end else begin
`ifdef FWD_PERF_CNT_EN
        m_sc++;
`endif
      end
    end
    cyc++;
  endtask

  task automatic tick();
    for (int i = 0; i < 6; i++) rf[i] = rnd128();
    do_cycle();
    @(negedge clk);
  endtask

  task automatic clear_in();
    rst = 1'b0; e_iv = 1'b0; o_iv = 1'b0; e_wr = 1'b0; o_wr = 1'b0;
    e_dst = '0; o_dst = '0; e_lat = '0; o_lat = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin e_st[k] = '0; o_st[k] = '0; end
    for (int i = 0; i < 6; i++) src[i] = 7'd100 + 7'(i);
  endtask

  // Monitor
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() != 0) begin
        e = q.pop_front();
        if (e.chk) begin
          check("stall", e.cyc, {127'd0, stall}, {127'd0, e.stall});
          check("dual_dst_err", e.cyc, {127'd0, dual_dst_err}, {127'd0, e.err});
          for (int i = 0; i < 6; i++) check(names[i], e.cyc, dout[i], e.op[i]);
          check("stall_cycles", e.cyc, {96'd0, stall_cycles}, {96'd0, e.sc});
          check("fwd_hits", e.cyc, {96'd0, fwd_hits}, {96'd0, e.fh});
          $display("cyc=%0d stall=%0b err=%0b e_ra=%h o_rb=%h", e.cyc, stall, dual_dst_err,
                   dout[0], dout[4]);
        end
      end
    end
  end

  // Driver
  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; m_op = '0; m_err = 1'b0; m_sc = 0; m_fh = 0;
    for (int r = 0; r < NUM_REGS; r++) ready[r] = 0;
    clear_in();
    @(negedge clk);
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    // No pending writes: RF data passes through
    src[0] = 7'd5; tick(); tick();
    // Even issue dst 9 lat 2, then its result forwarded from e_stage2
    e_iv = 1'b1; e_wr = 1'b1; e_dst = 7'd9; e_lat = 4'd2; src[4] = 7'd9; tick();
    e_iv = 1'b0; tick(); tick();
    e_st[1] = pk(1'b1, 7'd9, 4'd2, rnd128()); tick();
    e_st[1] = '0; tick();
    // Youngest stage wins; even wins at equal age
    src[1] = 7'd12;
    e_st[3] = pk(1'b1, 7'd12, 4'd4, rnd128()); o_st[0] = pk(1'b1, 7'd12, 4'd1, rnd128()); tick();
    e_st[3] = '0; o_st[0] = '0;
    e_st[2] = pk(1'b1, 7'd12, 4'd3, rnd128()); o_st[2] = pk(1'b1, 7'd12, 4'd3, rnd128()); tick();
    e_st[2] = '0; o_st[2] = '0; tick();
    // Dual issue to the same dst: odd latency wins, error flag
    e_iv = 1'b1; e_wr = 1'b1; e_dst = 7'd20; e_lat = 4'd6;
    o_iv = 1'b1; o_wr = 1'b1; o_dst = 7'd20; o_lat = 4'd2; tick();
    clear_in(); src[2] = 7'd20; tick(); tick(); tick(); tick();
    // WAW reload with a shorter latency, and clamp of latency 0
    clear_in();
    e_iv = 1'b1; e_wr = 1'b1; e_dst = 7'd30; e_lat = 4'd7; tick();
    e_lat = 4'd1; tick();
    e_iv = 1'b0; src[0] = 7'd30; tick(); tick();
    o_iv = 1'b1; o_wr = 1'b1; o_dst = 7'd31; o_lat = 4'd0; tick();
    o_iv = 1'b0; src[1] = 7'd31; repeat (9) tick();
    // Reset mid-flight clears pending state; issue presented during stall is ignored
    clear_in();
    e_iv = 1'b1; e_wr = 1'b1; e_dst = 7'd3; e_lat = 4'd7; tick();
    e_iv = 1'b0; src[3] = 7'd3; o_iv = 1'b1; o_wr = 1'b1; o_dst = 7'd40; o_lat = 4'd1; tick();
    o_iv = 1'b0; rst = 1'b1; tick();
    rst = 1'b0; src[5] = 7'd40; tick(); tick(); tick();
    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      clear_in();
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < 6; i++) src[i] = 7'($urandom_range(0, 15));
      e_iv = ($urandom_range(0, 3) == 0); e_wr = ($urandom_range(0, 3) != 0);
      o_iv = ($urandom_range(0, 3) == 0); o_wr = ($urandom_range(0, 3) != 0);
      e_dst = 7'($urandom_range(0, 15)); o_dst = 7'($urandom_range(0, 15));
      e_lat = 4'($urandom_range(0, 15)); o_lat = 4'($urandom_range(0, 15));
      for (int k = 0; k < NUM_STAGES; k++) begin
        if ($urandom_range(0, 2) == 0)
          e_st[k] = pk(1'($urandom), ($urandom_range(0, 3) == 0) ? 7'($urandom) :
                       src[$urandom_range(0, 5)], 4'($urandom_range(0, 8)), rnd128());
        if ($urandom_range(0, 2) == 0)
          o_st[k] = pk(1'($urandom), ($urandom_range(0, 3) == 0) ? 7'($urandom) :
                       src[$urandom_range(0, 5)], 4'($urandom_range(0, 8)), rnd128());
      end
      tick();
    end
    clear_in();
    tick();
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
